gru_sequencer: RTL and testbench

Sequence controller that drives one gruCell over a time series of SEQ_LEN input vectors. It accepts x_t vectors on a valid/ready stream and holds them stable at the cell inputs. It holds the recurrent hidden state in a register, feeds that state back as h_t_minus_1, and captures h_t after a fixed cell latency. After the last step it presents the final hidden state on a valid/ready output, where a downstream dense or output layer consumes it.

---
 rtl/gru_sequencer.sv | 116 +++++++++++
 tb/tb_gru_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gru_sequencer.sv
// Sequence controller for a single GRU cell: streams SEQ_LEN input vectors through the cell,
// recirculates the hidden state and presents the final state on a valid/ready output.
module gru_sequencer #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NFRAC        = 10,
    parameter int unsigned x_SIZE       = 32,
    parameter int unsigned h_SIZE       = 32,
    parameter int unsigned SEQ_LEN      = 8,
    parameter int unsigned CELL_LATENCY = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               x_valid,
    output logic                               x_ready,
    input  logic signed [WIDTH-1:0]            x_in [x_SIZE],
    output logic signed [WIDTH-1:0]            cell_x_t [x_SIZE],
    output logic signed [WIDTH-1:0]            cell_h_t_minus_1 [h_SIZE],
    input  logic signed [WIDTH-1:0]            cell_h_t [h_SIZE],
    output logic signed [WIDTH-1:0]            h_out [h_SIZE],
    output logic                               h_out_valid,
    input  logic                               h_out_ready,
    output logic                               busy,
    output logic [$clog2(SEQ_LEN+1)-1:0]       step_count
);

    localparam int unsigned StepW = $clog2(SEQ_LEN + 1);
    localparam int unsigned LatW  = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;

    localparam logic [StepW-1:0] SeqLenC = StepW'(SEQ_LEN);
    localparam logic [LatW-1:0]  LatLast = LatW'(CELL_LATENCY - 1);

    if (SEQ_LEN < 1) begin : g_bad_seq_len
        $error("gru_sequencer: SEQ_LEN must be at least 1");
    end
    if (CELL_LATENCY < 1) begin : g_bad_latency
        $error("gru_sequencer: CELL_LATENCY must be at least 1");
    end
    if (NFRAC >= WIDTH) begin : g_bad_nfrac
        $error("gru_sequencer: NFRAC must be smaller than WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StWaitX, StRun, StDone} state_e;

    state_e                   state_q, state_d;
    logic signed [WIDTH-1:0]  x_q [x_SIZE];
    logic signed [WIDTH-1:0]  x_d [x_SIZE];
    logic signed [WIDTH-1:0]  h_q [h_SIZE];
    logic signed [WIDTH-1:0]  h_d [h_SIZE];
    logic [StepW-1:0]         step_q, step_d;
    logic [LatW-1:0]          lat_q, lat_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '{default: '0};
            h_q     <= '{default: '0};
            step_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            h_q     <= h_d;
            step_q  <= step_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        step_d  = step_q;
        lat_d   = lat_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    h_d     = '{default: '0};
                    step_d  = '0;
                    state_d = StWaitX;
                end
            end
            StWaitX: begin
                if (x_valid) begin
                    x_d     = x_in;
                    lat_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                lat_d = lat_q + LatW'(1);
                // Capture on the last of CELL_LATENCY cycles with stable cell inputs.
                if (lat_q == LatLast) begin
                    h_d     = cell_h_t;
                    step_d  = step_q + StepW'(1);
                    state_d = (step_d == SeqLenC) ? StDone : StWaitX;
                end
            end
            StDone: begin
                if (h_out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign x_ready          = (state_q == StWaitX);
    assign h_out_valid      = (state_q == StDone);
    assign busy             = (state_q != StIdle);
    assign step_count       = step_q;
    assign cell_x_t         = x_q;
    assign cell_h_t_minus_1 = h_q;
    assign h_out            = h_q;

endmodule

// File: tb/tb_gru_sequencer.sv
// Bench for gru_sequencer: two instances (3-step/4-cycle and 1-step/1-cycle) driven by a
// summing stub cell, checked against a running-sum reference of the accepted input vectors.
module tb_gru_sequencer;

    localparam int W  = 32;
    localparam int XS = 6;
    localparam int HS = 4;
    localparam int SL = 3;
    localparam int CL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance 0: SEQ_LEN=3, CELL_LATENCY=4
    logic                start0, xv0, hr0, x_ready0, hv0, busy0;
    logic [1:0]          sc0;
    logic signed [W-1:0] x_in0 [XS];
    logic signed [W-1:0] cx0 [XS];
    logic signed [W-1:0] chm0 [HS];
    logic signed [W-1:0] cht0 [HS];
    logic signed [W-1:0] hout0 [HS];

    // Instance 1: SEQ_LEN=1, CELL_LATENCY=1
    logic                start1, xv1, hr1, x_ready1, hv1, busy1;
    logic [0:0]          sc1;
    logic signed [W-1:0] x_in1 [XS];
    logic signed [W-1:0] cx1 [XS];
    logic signed [W-1:0] chm1 [HS];
    logic signed [W-1:0] cht1 [HS];
    logic signed [W-1:0] hout1 [HS];

    gru_sequencer #(
        .WIDTH(W), .NFRAC(10), .x_SIZE(XS), .h_SIZE(HS), .SEQ_LEN(SL), .CELL_LATENCY(CL)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .x_valid(xv0), .x_ready(x_ready0),
        .x_in(x_in0), .cell_x_t(cx0), .cell_h_t_minus_1(chm0), .cell_h_t(cht0),
        .h_out(hout0), .h_out_valid(hv0), .h_out_ready(hr0), .busy(busy0), .step_count(sc0)
    );

    gru_sequencer #(
        .WIDTH(W), .NFRAC(10), .x_SIZE(XS), .h_SIZE(HS), .SEQ_LEN(1), .CELL_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .x_valid(xv1), .x_ready(x_ready1),
        .x_in(x_in1), .cell_x_t(cx1), .cell_h_t_minus_1(chm1), .cell_h_t(cht1),
        .h_out(hout1), .h_out_valid(hv1), .h_out_ready(hr1), .busy(busy1), .step_count(sc1)
    );

    // Stub cells h_t = h_t_minus_1 + x_t[0..HS-1]; valid exactly at the CL-th edge of
    // stable inputs, so an early capture picks up a stale sum.
    logic signed [W-1:0] p0 [HS];
    logic signed [W-1:0] p1 [HS];
    logic signed [W-1:0] p2 [HS];
    always_ff @(posedge clk) begin
        for (int i = 0; i < HS; i++) begin
            p0[i] <= chm0[i] + cx0[i];
            p1[i] <= p0[i];
            p2[i] <= p1[i];
        end
    end
    assign cht0 = p2;

    always_comb begin
        for (int i = 0; i < HS; i++) cht1[i] = chm1[i] + cx1[i];
    end

    int npass  = 0;
    int ntotal = 0;

    logic signed [W-1:0] xs [SL][XS];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ntotal = ntotal + 1;
        assert (obs === exp) npass = npass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    task automatic chk_h0(input string tag, input logic signed [W-1:0] e [HS]);
        for (int i = 0; i < HS; i++) chk($sformatf("%s h_out0[%0d]", tag, i), hout0[i], e[i]);
    endtask

    task automatic fill_xs(input logic signed [W-1:0] v);
        for (int s = 0; s < SL; s++)
            for (int i = 0; i < XS; i++) xs[s][i] = v;
    endtask

    // One full sequence on instance 0: optional input stall before step stall_step,
    // bp_len cycles of output backpressure (with a stray start pulse) in DONE.
    task automatic run0(input string tag, input int stall_step, input int stall_len,
                        input int bp_len);
        int cyc;
        int idx;
        int stall;
        bit exp_rdy;
        logic signed [W-1:0] m [HS];
        logic signed [W-1:0] zero [HS];
        for (int i = 0; i < HS; i++) begin
            m[i]    = '0;
            zero[i] = '0;
            for (int s = 0; s < SL; s++) m[i] = m[i] + xs[s][i];
        end
        start0 = 1'b1;
        @(negedge clk);
        start0  = 1'b0;
        cyc     = 0;
        idx     = 0;
        stall   = stall_len;
        exp_rdy = 1'b0;
        chk({tag, " start clears step_count"}, W'(sc0), 0);
        chk_h0({tag, " start clears h"}, zero);
        while (!hv0 && cyc < 200) begin
            if (exp_rdy) begin
                chk({tag, " x_ready held in stall"}, W'(x_ready0), 1);
                chk({tag, " no capture in stall"}, W'(sc0), W'(stall_step));
            end
            exp_rdy = 1'b0;
            if (x_ready0) begin
                if (idx == stall_step && stall > 0) begin
                    xv0     = 1'b0;
                    stall   = stall - 1;
                    exp_rdy = 1'b1;
                end else if (idx < SL) begin
                    xv0   = 1'b1;
                    x_in0 = xs[idx];
                    idx   = idx + 1;
                end else begin
                    chk({tag, " extra x_ready"}, W'(idx), W'(SL - 1));
                    xv0 = 1'b0;
                end
            end else begin
                xv0 = 1'b1;
                for (int i = 0; i < XS; i++) x_in0[i] = $urandom;
            end
            @(negedge clk);
            cyc = cyc + 1;
        end
        xv0 = 1'b0;
        chk({tag, " latency to h_out_valid"}, W'(cyc), W'(SL * (1 + CL) + stall_len));
        chk({tag, " step_count in DONE"}, W'(sc0), W'(SL));
        chk({tag, " busy in DONE"}, W'(busy0), 1);
        chk_h0({tag, " DONE"}, m);
        for (int k = 0; k < bp_len; k++) begin
            start0 = (k == 2);
            @(negedge clk);
            chk({tag, " h_out_valid under backpressure"}, W'(hv0), 1);
            chk_h0({tag, " backpressure"}, m);
        end
        start0 = 1'b0;
        hr0    = 1'b1;
        @(negedge clk);
        hr0 = 1'b0;
        chk({tag, " h_out_valid after handshake"}, W'(hv0), 0);
        chk({tag, " busy after handshake"}, W'(busy0), 0);
        chk({tag, " step_count kept in IDLE"}, W'(sc0), W'(SL));
        chk_h0({tag, " IDLE keeps h"}, m);
    endtask

    initial begin
        logic signed [W-1:0] zero [HS];
        int cyc;
        for (int i = 0; i < HS; i++) zero[i] = '0;
        reset  = 1'b1;
        start0 = 1'b1;
        xv0    = 1'b0;
        hr0    = 1'b0;
        start1 = 1'b0;
        xv1    = 1'b0;
        hr1    = 1'b0;
        for (int i = 0; i < XS; i++) begin
            x_in0[i] = '0;
            x_in1[i] = '0;
        end
        // start coincident with reset must be dropped
        repeat (3) @(negedge clk);
        start0 = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        chk("reset busy", W'(busy0), 0);
        chk("reset x_ready", W'(x_ready0), 0);
        chk("reset h_out_valid", W'(hv0), 0);
        chk("reset step_count", W'(sc0), 0);
        chk_h0("reset", zero);
        for (int i = 0; i < XS; i++) chk("reset cell_x_t", cx0[i], 0);
        for (int i = 0; i < HS; i++) chk("reset cell_h_t_minus_1", chm0[i], 0);

        // Reset in the middle of step 2
        fill_xs(32'sd1024);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        xv0    = 1'b1;
        x_in0  = xs[0];
        repeat (7) @(negedge clk);
        chk("midrun step_count", W'(sc0), 1);
        chk("midrun x_ready", W'(x_ready0), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        xv0   = 1'b0;
        chk("midreset busy", W'(busy0), 0);
        chk("midreset step_count", W'(sc0), 0);
        chk("midreset x_ready", W'(x_ready0), 0);
        chk("midreset h_out_valid", W'(hv0), 0);
        chk_h0("midreset", zero);
        for (int i = 0; i < XS; i++) chk("midreset cell_x_t", cx0[i], 0);
        repeat (5) @(negedge clk);
        chk("after reset busy", W'(busy0), 0);
        chk_h0("after reset", zero);

        run0("nominal", 0, 0, 0);
        run0("stall", 1, 5, 0);
        run0("backpressure", 0, 0, 10);
        fill_xs(-32'sd512);
        run0("signed first", 0, 0, 0);
        run0("signed back-to-back", 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < SL; s++)
                for (int i = 0; i < XS; i++) xs[s][i] = $urandom;
            run0($sformatf("random%0d", r), int'($urandom_range(0, SL - 1)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        // Degenerate instance: one step, one cycle of latency
        hr1 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < XS; i++) x_in1[i] = $urandom;
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            xv1    = 1'b1;
            cyc    = 0;
            while (!hv1 && cyc < 20) begin
                @(negedge clk);
                cyc = cyc + 1;
            end
            xv1 = 1'b0;
            chk("deg latency", W'(cyc), 2);
            chk("deg step_count", W'(sc1), 1);
            for (int i = 0; i < HS; i++) chk("deg h_out", hout1[i], x_in1[i]);
            @(negedge clk);
            chk("deg busy after handshake", W'(busy1), 0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", npass, ntotal);
        $fatal(1, "watchdog expired");
    end

endmodule
